// File: rtl/fb_text_writer_pkg.sv
// Shared text frame-buffer constants, control codes, writer state and cursor command encodings.
// Frame-buffer geometry must stay in step with the VGA address generator.
package fb_text_writer_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned COL_W   = 7;
    localparam int unsigned ROW_W   = 6;

    localparam logic [ADDR_W-1:0]  FB_BASE_DEF = 16'h3000;
    localparam int unsigned        COLS_DEF    = 80;
    localparam int unsigned        ROWS_DEF    = 60;
    localparam logic [GLYPH_W-1:0] BLANK_DEF   = 8'h00;

    localparam logic [GLYPH_W-1:0] CC_LF = 8'h0A;
    localparam logic [GLYPH_W-1:0] CC_BS = 8'h08;
    localparam logic [GLYPH_W-1:0] CC_FF = 8'h0C;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RDWAIT = 3'd2,
        WR     = 3'd3,
        CLR    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CUR_HOLD    = 3'd0,
        CUR_ADVANCE = 3'd1,
        CUR_RETREAT = 3'd2,
        CUR_NEWLINE = 3'd3,
        CUR_HOME    = 3'd4
    } cur_cmd_t;

    // Replace one glyph lane of a frame-buffer word; odd columns live in the low byte.
    function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0]  word,
                                                     input logic [GLYPH_W-1:0] glyph,
                                                     input logic               odd);
        return odd ? {word[DATA_W-1:GLYPH_W], glyph} : {glyph, word[GLYPH_W-1:0]};
    endfunction

endpackage

// File: rtl/fb_text_writer_cursor.sv
// Text cursor: column/row counters with advance, retreat, newline and home, all wrapping.
// prev_col_c/prev_row_c expose the cell a retreat would land on.
module fb_cursor
    import fb_text_writer_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF,
    parameter int unsigned ROWS = ROWS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  cur_cmd_t         cmd,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] prev_col_c,
    output logic [ROW_W-1:0] prev_row_c
);

    logic [ROW_W-1:0] next_row;

    always_comb begin
        next_row   = (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
        prev_col_c = col - COL_W'(1);
        prev_row_c = row;
        if (col == '0) begin
            prev_col_c = COL_W'(COLS - 1);
            prev_row_c = (row == '0) ? ROW_W'(ROWS - 1) : row - ROW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else begin
            case (cmd)
                CUR_ADVANCE: begin
                    if (col == COL_W'(COLS - 1)) begin
                        col <= '0;
                        row <= next_row;
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                CUR_RETREAT: begin
                    col <= prev_col_c;
                    row <= prev_row_c;
                end
                CUR_NEWLINE: begin
                    col <= '0;
                    row <= next_row;
                end
                CUR_HOME: begin
                    col <= '0;
                    row <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fb_text_writer.sv
// Glyph/control byte stream to text frame-buffer writer with hardware cursor.
// Glyphs are placed by read-modify-write so the neighbouring lane is preserved.
module fb_text_writer
    import fb_text_writer_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH  = ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] FB_BASE    = ADDR_WIDTH'(FB_BASE_DEF),
    parameter int unsigned          COLS        = COLS_DEF,
    parameter int unsigned          ROWS        = ROWS_DEF,
    parameter logic [GLYPH_W-1:0]   BLANK_GLYPH = BLANK_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [GLYPH_W-1:0]    ch_data,
    input  logic                  ch_valid,
    output logic                  ch_ready,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [COL_W-1:0]      cursor_col,
    output logic [ROW_W-1:0]      cursor_row,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = FB_BASE + ADDR_WIDTH'(COLS * ROWS / 2 - 1);

    state_t                state, state_n;
    cur_cmd_t              cur_cmd;
    logic [GLYPH_W-1:0]    glyph_q, glyph_n;
    logic                  bs_q, bs_n;
    logic                  req_n, we_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_W-1:0]     wdata_n;
    logic [COL_W-1:0]      prev_col;
    logic [ROW_W-1:0]      prev_row;
    logic                  accept;

    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [COL_W-1:0] c,
                                                         input logic [ROW_W-1:0] r);
        return FB_BASE + ADDR_WIDTH'(r) * ADDR_WIDTH'(COLS / 2) + ADDR_WIDTH'(c[COL_W-1:1]);
    endfunction

    fb_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cur_cmd),
        .col        (cursor_col),
        .row        (cursor_row),
        .prev_col_c (prev_col),
        .prev_row_c (prev_row)
    );

    assign ch_ready = (state == IDLE) && reset;
    assign busy     = (state != IDLE);
    assign accept   = ch_valid && ch_ready;

    // Next state and next registered memory-port values; an ungranted access holds everything.
    always_comb begin
        state_n = state;
        req_n   = mem_req;
        we_n    = mem_we;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        glyph_n = glyph_q;
        bs_n    = bs_q;
        cur_cmd = CUR_HOLD;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (ch_data)
                        CC_LF: cur_cmd = CUR_NEWLINE;
                        CC_FF: begin
                            cur_cmd = CUR_HOME;
                            state_n = CLR;
                            req_n   = 1'b1;
                            we_n    = 1'b1;
                            addr_n  = FB_BASE;
                            wdata_n = {BLANK_GLYPH, BLANK_GLYPH};
                        end
                        CC_BS: begin
                            if ((cursor_col != '0) || (cursor_row != '0)) begin
                                cur_cmd = CUR_RETREAT;
                                glyph_n = BLANK_GLYPH;
                                bs_n    = 1'b1;
                                state_n = RD;
                                req_n   = 1'b1;
                                we_n    = 1'b0;
                                addr_n  = cell_addr(prev_col, prev_row);
                            end
                        end
                        default: begin
                            glyph_n = ch_data;
                            bs_n    = 1'b0;
                            state_n = RD;
                            req_n   = 1'b1;
                            we_n    = 1'b0;
                            addr_n  = cell_addr(cursor_col, cursor_row);
                        end
                    endcase
                end
            end
            RD: begin
                if (mem_gnt) begin
                    state_n = RDWAIT;
                    req_n   = 1'b0;
                end
            end
            RDWAIT: begin
                state_n = WR;
                req_n   = 1'b1;
                we_n    = 1'b1;
                wdata_n = lane_merge(mem_rdata, glyph_q, cursor_col[0]);
            end
            WR: begin
                if (mem_gnt) begin
                    state_n = IDLE;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    if (!bs_q) cur_cmd = CUR_ADVANCE;
                end
            end
            CLR: begin
                if (mem_gnt) begin
                    if (mem_addr == LAST_ADDR) begin
                        state_n = IDLE;
                        req_n   = 1'b0;
                        we_n    = 1'b0;
                    end else begin
                        addr_n = mem_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
                we_n    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= FB_BASE;
            mem_wdata <= '0;
            glyph_q   <= '0;
            bs_q      <= 1'b0;
        end else begin
            state     <= state_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            glyph_q   <= glyph_n;
            bs_q      <= bs_n;
        end
    end

endmodule
